// File: rtl/register_vga_renderer_if.sv
// Video-side bundle of the register VGA renderer: the 176-bit register debug bus in,
// sync and 3-bit colour channels out.
interface register_vga_renderer_if;
  logic [175:0] registersVGA;
  logic         hs;
  logic         vs;
  logic [2:0]   r;
  logic [2:0]   g;
  logic [2:0]   b;

  modport master (output registersVGA, input hs, vs, r, g, b);
  modport slave  (input registersVGA, output hs, vs, r, g, b);
endinterface

// File: rtl/register_vga_renderer.sv
// 640x480@60 scan-out of R0-R7, IH, SP, RA as seven-segment hex from a per-frame bus snapshot.
// Optional REGVGA_CHANGE_HIGHLIGHT_EN: rows that changed at a snapshot render red for 30 frames.
module register_vga_renderer #(
  parameter int X0 = 64,
  parameter int Y0 = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  register_vga_renderer_if.slave  vga
);

  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd524;
  localparam logic [9:0] X0_C   = 10'(X0);
  localparam logic [9:0] Y0_C   = 10'(Y0);

  logic [9:0]   hcnt_q, vcnt_q, hcnt_d, vcnt_d;
  logic [175:0] snap_q;
  logic         hs_q, vs_q, hs_d, vs_d;
  logic [2:0]   r_q, g_q, b_q, r_d, g_d, b_d;

  logic         snap_cyc_s;
  logic         visible_s, in_text_s, lit_s, red_s;
  logic [9:0]   relx_s, rely_s;
  logic [3:0]   row_s, cx_s, nib_s;
  logic [4:0]   cy_s;
  logic [1:0]   digit_s;
  logic [15:0]  word_s;
  logic [6:0]   segs_s;
  logic [15:0]  hl_row_s;
  logic [15:0]  rows_s [16];

  // Segment bits are {a,b,c,d,e,f,g}, MSB first.
  function automatic logic [6:0] hex_segs(input logic [3:0] n);
    case (n)
      4'h0:    return 7'b1111110;
      4'h1:    return 7'b0110000;
      4'h2:    return 7'b1101101;
      4'h3:    return 7'b1111001;
      4'h4:    return 7'b0110011;
      4'h5:    return 7'b1011011;
      4'h6:    return 7'b1011111;
      4'h7:    return 7'b1110000;
      4'h8:    return 7'b1111111;
      4'h9:    return 7'b1111011;
      4'hA:    return 7'b1110111;
      4'hB:    return 7'b0011111;
      4'hC:    return 7'b1001110;
      4'hD:    return 7'b0111101;
      4'hE:    return 7'b1001111;
      4'hF:    return 7'b1000111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] seg_boxes(input logic [3:0] cx, input logic [4:0] cy);
    logic [6:0] s;
    s[6] = (cx >= 4'd3)  && (cx <= 4'd12) && (cy >= 5'd2)  && (cy <= 5'd4);
    s[5] = (cx >= 4'd12) && (cx <= 4'd14) && (cy >= 5'd3)  && (cy <= 5'd15);
    s[4] = (cx >= 4'd12) && (cx <= 4'd14) && (cy >= 5'd17) && (cy <= 5'd29);
    s[3] = (cx >= 4'd3)  && (cx <= 4'd12) && (cy >= 5'd28) && (cy <= 5'd30);
    s[2] = (cx >= 4'd1)  && (cx <= 4'd3)  && (cy >= 5'd17) && (cy <= 5'd29);
    s[1] = (cx >= 4'd1)  && (cx <= 4'd3)  && (cy >= 5'd3)  && (cy <= 5'd15);
    s[0] = (cx >= 4'd3)  && (cx <= 4'd12) && (cy >= 5'd15) && (cy <= 5'd17);
    return s;
  endfunction

  // Rows past RA read as zero so the row index never needs a range guard.
  for (genvar k = 0; k < 16; k++) begin : g_rows
    if (k < 11) begin : g_live
      assign rows_s[k] = snap_q[175-16*k -: 16];
    end else begin : g_pad
      assign rows_s[k] = 16'h0000;
    end
  end

`ifdef REGVGA_CHANGE_HIGHLIGHT_EN
  logic [4:0] hold_q [11];

  // Per-row change-highlight hold counters, advanced only on the snapshot cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 11; k++) hold_q[k] <= 5'd0;
    end else if (snap_cyc_s) begin
      for (int k = 0; k < 11; k++) begin
        if (vga.registersVGA[175-16*k -: 16] != rows_s[k]) hold_q[k] <= 5'd30;
        else if (hold_q[k] != 5'd0)                         hold_q[k] <= hold_q[k] - 5'd1;
      end
    end
  end

  // Row-wise highlight flags.
  always_comb begin
    hl_row_s = 16'h0000;
    for (int k = 0; k < 11; k++) hl_row_s[k] = (hold_q[k] != 5'd0);
  end
`else
  assign hl_row_s = 16'h0000;
`endif

  // Next scan position, glyph lookup and next output values.
  always_comb begin
    snap_cyc_s = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    if (hcnt_q == H_LAST) begin
      hcnt_d = 10'd0;
      if (vcnt_q == V_LAST) vcnt_d = 10'd0;
      else                  vcnt_d = vcnt_q + 10'd1;
    end else begin
      hcnt_d = hcnt_q + 10'd1;
      vcnt_d = vcnt_q;
    end

    relx_s    = hcnt_q - X0_C;
    rely_s    = vcnt_q - Y0_C;
    visible_s = (hcnt_q < 10'd640) && (vcnt_q < 10'd480);
    in_text_s = (hcnt_q >= X0_C) && (relx_s < 10'd64) && (vcnt_q >= Y0_C) && (rely_s < 10'd352);
    row_s     = rely_s[8:5];
    cy_s      = rely_s[4:0];
    digit_s   = relx_s[5:4];
    cx_s      = relx_s[3:0];
    word_s    = rows_s[row_s];
    red_s     = hl_row_s[row_s];

    case (digit_s)
      2'd0:    nib_s = word_s[15:12];
      2'd1:    nib_s = word_s[11:8];
      2'd2:    nib_s = word_s[7:4];
      2'd3:    nib_s = word_s[3:0];
      default: nib_s = 4'h0;
    endcase
    segs_s = hex_segs(nib_s) & seg_boxes(cx_s, cy_s);
    lit_s  = in_text_s && (segs_s != 7'd0);

    if (visible_s && lit_s) begin
      r_d = 3'd7;
      g_d = red_s ? 3'd0 : 3'd7;
      b_d = red_s ? 3'd0 : 3'd7;
    end else begin
      r_d = 3'd0;
      g_d = 3'd0;
      b_d = 3'd0;
    end

    hs_d = ~((hcnt_q >= 10'd656) && (hcnt_q <= 10'd751));
    vs_d = ~((vcnt_q >= 10'd490) && (vcnt_q <= 10'd491));
  end

  // Scan counters, frame snapshot and one-cycle-registered video outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt_q <= 10'd0;
      vcnt_q <= 10'd0;
      snap_q <= 176'd0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      r_q    <= 3'd0;
      g_q    <= 3'd0;
      b_q    <= 3'd0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      if (snap_cyc_s) snap_q <= vga.registersVGA;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign vga.hs = hs_q;
  assign vga.vs = vs_q;
  assign vga.r  = r_q;
  assign vga.g  = g_q;
  assign vga.b  = b_q;

endmodule

// File: tb/tb_register_vga_renderer.sv
// Directed scoreboard bench for register_vga_renderer: sync widths, glyph pixels,
// frame-snapshot behaviour, mid-line reset and the optional change highlight.
module tb_register_vga_renderer;

  localparam int X0 = 64;
  localparam int Y0 = 48;
  localparam logic [8:0] WHT = 9'h1FF;
  localparam logic [8:0] BLK = 9'h000;
  localparam logic [8:0] RED = 9'h1C0;
`ifdef REGVGA_CHANGE_HIGHLIGHT_EN
  localparam logic [8:0] HL = RED;
  localparam int HL_FRAMES = 31;
`else
  localparam logic [8:0] HL = WHT;
  localparam int HL_FRAMES = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  register_vga_renderer_if bus();

  register_vga_renderer #(.X0(X0), .Y0(Y0)) dut (
    .clk (clk),
    .rst (rst),
    .vga (bus)
  );

  always #20 clk = ~clk;

  // Reference scan position (counter value during the current cycle).
  int m_h = 0;
  int m_v = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_h <= 0;
      m_v <= 0;
    end else if (m_h == 799) begin
      m_h <= 0;
      m_v <= (m_v == 524) ? 0 : m_v + 1;
    end else begin
      m_h <= m_h + 1;
    end
  end

  // Sync-low accumulators over a measurement window.
  logic cnt_en = 1'b0;
  int hs_low = 0;
  int vs_low = 0;
  always @(negedge clk) begin
    if (cnt_en) begin
      if (!bus.hs) hs_low <= hs_low + 1;
      if (!bus.vs) vs_low <= vs_low + 1;
    end
  end

  typedef struct { string tag; logic [10:0] exp; } sb_t;
  sb_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [10:0] exp_px(int x, int y, logic [8:0] rgb);
    logic hs_e, vs_e;
    hs_e = !((x >= 656) && (x <= 751));
    vs_e = !((y >= 490) && (y <= 491));
    return {hs_e, vs_e, rgb};
  endfunction

  task automatic check_now();
    sb_t e;
    logic [10:0] obs;
    e   = sb_q.pop_front();
    obs = {bus.hs, bus.vs, bus.r, bus.g, bus.b};
    n_cmp++;
    assert (obs === e.exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic cmp_int(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic goto(int x, int y, string tag);
    int budget = 0;
    while (!(m_h == x && m_v == y) && budget < 450000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (budget >= 450000) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: position (%0d,%0d) not reached, observed timeout expected arrival", tag, x, y);
    end
  endtask

  // Counters at (x,y) this cycle produce the registered pixel one edge later.
  task automatic expect_px(int x, int y, logic [8:0] rgb, string tag);
    goto(x, y, tag);
    sb_q.push_back('{tag: tag, exp: exp_px(x, y, rgb)});
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic set_reg(int k, logic [15:0] v);
    bus.registersVGA[175-16*k -: 16] = v;
  endtask

  initial begin
    int n;
    bus.registersVGA = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb_q.push_back('{tag: "reset_state", exp: {1'b1, 1'b1, BLK}});
    check_now();
    @(negedge clk);
    rst = 1'b1;

    // Frame 0: snapshot is all zero; bus changes mid-frame stay invisible.
    goto(0, 20, "f0_start");
    set_reg(0, 16'h8000);
    set_reg(10, 16'h000F);
    expect_px(X0 + 3,  Y0 + 2,   WHT, "f0_r0_seg_a");
    expect_px(X0 + 5,  Y0 + 16,  BLK, "f0_r0_seg_g_old");
    expect_px(X0 + 19, Y0 + 16,  BLK, "f0_r0_d1_seg_g");
    expect_px(655, 100, BLK, "hs_before");
    expect_px(656, 100, BLK, "hs_first");
    expect_px(751, 100, BLK, "hs_last");
    expect_px(752, 100, BLK, "hs_after");
    expect_px(X0 + 61, Y0 + 325, WHT, "f0_ra_seg_b_old");
    expect_px(X0 + 49, Y0 + 340, WHT, "f0_ra_seg_e");
    expect_px(0, 489, BLK, "vs_before");
    expect_px(0, 490, BLK, "vs_first");
    expect_px(5, 491, BLK, "vs_last");
    expect_px(0, 492, BLK, "vs_after");

    // Change present only during the snapshot cycle must be captured.
    goto(799, 524, "snap_cycle");
    set_reg(4, 16'h8888);
    @(posedge clk);
    #1;
    set_reg(4, 16'h0000);
    cnt_en = 1'b1;

    // Frame 1.
    expect_px(X0 + 3,  Y0 + 2,   HL,  "f1_r0_seg_a");
    expect_px(X0 + 5,  Y0 + 16,  HL,  "f1_r0_seg_g_new");
    expect_px(X0 + 19, Y0 + 16,  BLK, "f1_r0_d1_seg_g");
    goto(0, 100, "f1_r3_change");
    set_reg(3, 16'h0001);
    expect_px(X0 + 53, Y0 + 99,  WHT, "f1_r3_old_seg_a");
    expect_px(X0 + 5,  Y0 + 144, HL,  "f1_r4_snap_edge");
    expect_px(X0 + 61, Y0 + 325, BLK, "f1_ra_seg_b");
    expect_px(X0 + 49, Y0 + 340, HL,  "f1_ra_seg_e");

    // Frame 2.
    expect_px(X0 + 53, Y0 + 99,  BLK, "f2_r3_new_seg_a");
    expect_px(X0 + 61, Y0 + 116, HL,  "f2_r3_new_seg_c");
    expect_px(X0 + 5,  Y0 + 144, BLK, "f2_r4_cleared");

    goto(0, 0, "f3_start");
    cnt_en = 1'b0;
    cmp_int("hs_low_2frames", hs_low, 2 * 525 * 96);
    cmp_int("vs_low_2frames", vs_low, 2 * 2 * 800);

    // Mid-line asynchronous reset.
    goto(300, 200, "rst_point");
    rst = 1'b0;
    #1;
    sb_q.push_back('{tag: "async_reset", exp: {1'b1, 1'b1, BLK}});
    check_now();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.hs && n < 2000);
    cmp_int("hs_edges_after_release", n, 657);
    expect_px(X0 + 5, Y0 + 16, BLK, "post_rst_snap_zero");

    // Change SP once and watch its row colour frame by frame.
    goto(0, 400, "sp_change");
    set_reg(9, 16'h8888);
    for (int f = 0; f < HL_FRAMES; f++) begin
`ifdef REGVGA_CHANGE_HIGHLIGHT_EN
      expect_px(X0 + 5, Y0 + 304, (f < 30) ? RED : WHT, "sp_row_colour");
`else
      expect_px(X0 + 5, Y0 + 304, WHT, "sp_row_colour");
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_vga_renderer.md
# register_vga_renderer

Consumer of the register file's 176-bit debug bus: scans out a 640x480@60 VGA frame showing R0–R7, IH, SP and RA as 4-digit hex, drawn as seven-segment glyphs. Sits between the register file and the board VGA connector and runs on the 25 MHz pixel clock. It snapshots the bus once per frame so a frame never shows a mix of old and new values.

## Interface
Parameters:
- `X0`, 64: left pixel of the text area.
- `Y0`, 48: top line of the text area.

Ports:
- `clk` input 1: 25 MHz pixel clock.
- `rst` input 1: reset, asynchronous, active-low.
- `registersVGA` input 176: register values. `[175:160]` = R0, then in order through `[15:0]` = RA (index 10).
- `hs` output 1: horizontal sync, active-low.
- `vs` output 1: vertical sync, active-low.
- `r`, `g`, `b` output 3 each: pixel colour.

## Operation
- `hcnt` counts 0–799 and wraps. `vcnt` increments when `hcnt` wraps, counts 0–524 and wraps.
- Visible area: `hcnt < 640` and `vcnt < 480`. Outside it, `r`/`g`/`b` = 0.
- Horizontal sync is asserted for `hcnt` 656–751. Vertical sync is asserted for `vcnt` 490–491.
- Snapshot: on the cycle where `hcnt==799` and `vcnt==524`, `snap <= registersVGA`. Rendering uses only `snap`.
- Layout:
  - Row k (0–10) covers y in [Y0+32k, Y0+32k+32).
  - Digit d (0–3) covers x in [X0+16d, X0+16d+16).
  - Digit 0 is nibble `[15:12]` of register k; digit 3 is nibble `[3:0]`.
- Cell-local coordinates: cx 0–15, cy 0–31. Segment boxes (inclusive):
  - a: x3–12, y2–4
  - b: x12–14, y3–15
  - c: x12–14, y17–29
  - d: x3–12, y28–30
  - e: x1–3, y17–29
  - f: x1–3, y3–15
  - g: x3–12, y15–17
- Segment sets, standard hex encoding:
  - 0 = abcdef, 1 = bc, 2 = abdeg, 3 = abcdg
  - 4 = bcfg, 5 = acdfg, 6 = acdefg, 7 = abc
  - 8 = all, 9 = abcdfg, A = abcefg, b = cdefg
  - C = adef, d = bcdeg, E = adefg, F = aefg
- A pixel inside a lit segment is foreground: 7/7/7. All other pixels are 0/0/0.

## Timing
- Reset state: `hcnt = vcnt = 0`, `snap = 0`, `hs = vs = 1`, `r = g = 0`, `b = 0`.
- After reset the first frame displays all zeros, i.e. "0000" on every row.
- `hs`, `vs` and the colour outputs are all registered and share one cycle of latency:
  - Outputs at cycle t+1 reflect the counters at cycle t.
  - Sync and colour stay mutually aligned.
- A bus change mid-frame is invisible until the next frame boundary.
- A change exactly on the snapshot cycle is captured.
- Reset asserted mid-line immediately forces the reset state. Scan restarts at (0,0) on the first clock after release.

## Configuration
- `REGVGA_CHANGE_HIGHLIGHT_EN` defined:
  - Each row has a 5-bit hold counter, reset value 0.
  - On the snapshot cycle, if the new value ≠ the old `snap` row, the counter loads 30. Otherwise a nonzero counter decrements by 1.
  - While a row's counter is nonzero, its foreground is 7/0/0 (red).
- `REGVGA_CHANGE_HIGHLIGHT_EN` undefined: no counters exist, and all foreground is white.

## Test plan
- Reset then run 2 frames: `hs` is low for exactly 96 clocks per 800-clock line, and `vs` is low for exactly 2 lines per 525-line frame.
- `registersVGA` with R0 = 16'h8000: pixel (X0+3, Y0+2), segment a of digit '8', is 7/7/7. Pixel (X0+16+3, Y0+16), digit '0' at segment g, is 0.
- RA = 16'h000F: pixel (X0+48+1, Y0+320+20), segment e of 'F', is white. Pixel (X0+48+13, Y0+320+5), segment b, is black.
- Change R3 at `vcnt == 100` mid-frame: the current frame still shows the old value, and the next frame shows the new one.
- Assert `rst` at `hcnt = 300`, `vcnt = 200`: outputs go to their reset values asynchronously, and `hcnt == 0` on the first cycle after release.
- With the macro defined, change SP once: row 9 is red for 30 frames and white from frame 31. Without the macro, row 9 stays white throughout.
